// File: rtl/soc_system_st_channel_filter_pipe_if.sv
// Avalon-ST beat bundle: valid/ready handshake plus packet framing.
// The master drives the beat and the slave drives ready.
interface soc_system_st_channel_filter_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CHAN_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CHAN_W-1:0] channel;
  logic              startofpacket;
  logic              endofpacket;

  modport master (
    output valid,
    output data,
    output channel,
    output startofpacket,
    output endofpacket,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  channel,
    input  startofpacket,
    input  endofpacket,
    output ready
  );
endinterface

// File: rtl/soc_system_st_channel_filter_pipe.sv
// Avalon-ST channel filter: forwards packets on channels <= MAX_CHANNEL
// through a registered 2-entry skid buffer and drops the rest.
module soc_system_st_channel_filter_pipe #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 8,
  parameter int OUT_CHAN_W  = 1,
  parameter int MAX_CHANNEL = 0,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  soc_system_st_channel_filter_pipe_if.slave  in_st,
  soc_system_st_channel_filter_pipe_if.master out_st,
  input  logic                 clear_stats,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 drop_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [OUT_CHAN_W-1:0] channel;
    logic                  sop;
    logic                  eop;
  } beat_t;

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [OUT_CHAN_W-1:0] chan_q;
  logic [OUT_CHAN_W-1:0] chan_n;
  logic [OUT_CHAN_W-1:0] fwd_chan;
  logic [1:0]            count;
  logic [1:0]            count_n;
  beat_t                 head;
  beat_t                 head_n;
  beat_t                 skid;
  beat_t                 skid_n;
  beat_t                 nb;
  logic                  rdy;
  logic                  vld;
  logic                  accept;
  logic                  pop;
  logic                  fwd;
  logic                  drop_inc;
  logic                  err_set;
  logic                  in_range;

  assign accept   = in_st.valid & rdy;
  assign pop      = vld & out_st.ready;
  assign in_range = in_st.channel <= IN_CHAN_W'(MAX_CHANNEL);

  always_comb begin
    state_n  = state;
    chan_n   = chan_q;
    fwd_chan = chan_q;
    fwd      = 1'b0;
    drop_inc = 1'b0;
    err_set  = 1'b0;
    if (accept) begin
      if (in_st.startofpacket) begin
        // a new SOP always restarts, even mid-packet
        err_set = (state != S_IDLE);
        if (in_range) begin
          fwd      = 1'b1;
          fwd_chan = in_st.channel[OUT_CHAN_W-1:0];
          chan_n   = fwd_chan;
          state_n  = in_st.endofpacket ? S_IDLE : S_PASS;
        end else begin
          drop_inc = 1'b1;
          state_n  = in_st.endofpacket ? S_IDLE : S_DROP;
        end
      end else begin
        unique case (1'b1)
          (state == S_IDLE): err_set = 1'b1;
          (state == S_PASS): begin
            fwd = 1'b1;
            if (in_st.endofpacket) state_n = S_IDLE;
          end
          (state == S_DROP): begin
            if (in_st.endofpacket) state_n = S_IDLE;
          end
          default: state_n = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    nb.data    = in_st.data;
    nb.channel = fwd_chan;
    nb.sop     = in_st.startofpacket;
    nb.eop     = in_st.endofpacket;
    head_n     = head;
    skid_n     = skid;
    count_n    = count;
    unique case ({fwd, pop})
      2'b10: begin
        if (count == 2'd0) head_n = nb;
        else               skid_n = nb;
        count_n = count + 2'd1;
      end
      2'b01: begin
        if (count == 2'd2) head_n = skid;
        count_n = count - 2'd1;
      end
      2'b11: begin
        if (count == 2'd1) begin
          head_n = nb;
        end else begin
          head_n = skid;
          skid_n = nb;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      chan_q <= '0;
      count  <= '0;
      head   <= '0;
      skid   <= '0;
      rdy    <= 1'b0;
      vld    <= 1'b0;
    end else begin
      state  <= state_n;
      chan_q <= chan_n;
      count  <= count_n;
      head   <= head_n;
      skid   <= skid_n;
      rdy    <= (count_n < 2'd2);
      vld    <= (count_n != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      drop_err   <= 1'b0;
    end else if (clear_stats) begin
      drop_count <= '0;
      drop_err   <= 1'b0;
    end else begin
      if (drop_inc && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      if (err_set)
        drop_err <= 1'b1;
    end
  end

  assign in_st.ready          = rdy;
  assign out_st.valid         = vld;
  assign out_st.data          = head.data;
  assign out_st.channel       = head.channel;
  assign out_st.startofpacket = head.sop;
  assign out_st.endofpacket   = head.eop;

endmodule

// File: tb/tb_soc_system_st_channel_filter_pipe.sv
// Bench: directed packets; expected output beats go into a queue
// that a negedge monitor pops whenever out_valid & out_ready.
module tb_soc_system_st_channel_filter_pipe;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_stats = 1'b0;
  logic [1:0] drop_count;
  logic       drop_err;

  soc_system_st_channel_filter_pipe_if #(
    .DATA_W(8), .CHAN_W(8)) in_bus ();
  soc_system_st_channel_filter_pipe_if #(
    .DATA_W(8), .CHAN_W(1)) out_bus ();

  always #5 clk = ~clk;

  soc_system_st_channel_filter_pipe #(
    .DATA_W(8),
    .IN_CHAN_W(8),
    .OUT_CHAN_W(1),
    .MAX_CHANNEL(0),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_st(in_bus),
    .out_st(out_bus),
    .clear_stats(clear_stats),
    .drop_count(drop_count),
    .drop_err(drop_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       chan;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_bus.valid && out_bus.ready) begin
      mon_a = '{out_bus.data, out_bus.channel,
                out_bus.startofpacket, out_bus.endofpacket};
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_beat: got %0h expected none", mon_a);
      end else begin
        mon_e = q.pop_front();
        chk("out_beat", 32'(mon_a), 32'(mon_e));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] ch,
                      input logic sop, input logic eop,
                      input logic fwd, output int stalls);
    bit done;
    in_bus.valid         = 1'b1;
    in_bus.data          = d;
    in_bus.channel       = ch;
    in_bus.startofpacket = sop;
    in_bus.endofpacket   = eop;
    stalls = 0;
    done   = 0;
    while (!done) begin
      @(negedge clk);
      if (in_bus.ready) begin
        done = 1;
      end else begin
        stalls++;
        if (stalls >= 60) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: got stalled expected accept");
          done = 1;
        end
      end
    end
    if (in_bus.ready && fwd)
      q.push_back('{d, 1'b0, sop, eop});
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    in_bus.valid         = 1'b0;
    in_bus.data          = '0;
    in_bus.channel       = '0;
    in_bus.startofpacket = 1'b0;
    in_bus.endofpacket   = 1'b0;
    out_bus.ready        = 1'b0;

    #12;
    chk("rst_in_ready", in_bus.ready, 0);
    chk("rst_out_valid", out_bus.valid, 0);
    chk("rst_out_data", out_bus.data, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_drop_err", drop_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", in_bus.ready, 1);

    // T1: 4-beat ch0 packet, latency 1
    out_bus.ready = 1'b1;
    send(8'h11, 8'h00, 1, 0, 1, s);
    chk("lat_valid", out_bus.valid, 1);
    chk("lat_data", out_bus.data, 8'h11);
    chk("lat_sop", out_bus.startofpacket, 1);
    send(8'h22, 8'hA5, 0, 0, 1, s);
    send(8'h33, 8'hA5, 0, 0, 1, s);
    send(8'h44, 8'hA5, 0, 1, 1, s);
    drain();

    // T2: ch5 packet dropped, ch0 packet passes
    for (int i = 0; i < 3; i++) begin
      send(8'h50 + 8'(i), (i == 0) ? 8'h05 : 8'hA5,
           i == 0, i == 2, 0, s);
      chk("drop_no_stall", s, 0);
    end
    send(8'h61, 8'h00, 1, 0, 1, s);
    send(8'h62, 8'hA5, 0, 1, 1, s);
    drain();
    chk("drop_count_1", drop_count, 1);
    chk("drop_err_clean", drop_err, 0);

    // T3: backpressure, 8-beat stream
    out_bus.ready = 1'b0;
    send(8'h80, 8'h00, 1, 0, 1, s);
    send(8'h81, 8'hA5, 0, 0, 1, s);
    chk("full_in_ready", in_bus.ready, 0);
    @(posedge clk);
    #1;
    chk("stall_valid", out_bus.valid, 1);
    chk("stall_data", out_bus.data, 8'h80);
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_bus.ready = 1'b1;
      end
      begin
        for (int i = 2; i < 8; i++)
          send(8'h80 + 8'(i), 8'hA5, 0, i == 7, 1, s);
      end
    join
    drain();

    // T4: orphan, then missing EOP, then clear
    send(8'h90, 8'h00, 0, 0, 0, s);
    chk("orphan_err", drop_err, 1);
    chk("orphan_count", drop_count, 1);
    send(8'h91, 8'h00, 1, 0, 1, s);
    send(8'h92, 8'h00, 1, 1, 1, s);
    drain();
    clear_stats = 1'b1;
    send(8'h93, 8'h03, 1, 1, 0, s);
    clear_stats = 1'b0;
    chk("clr_count", drop_count, 0);
    chk("clr_err", drop_err, 0);
    send(8'h94, 8'h00, 1, 0, 1, s);
    chk("pass_no_err", drop_err, 0);
    send(8'h95, 8'h00, 1, 1, 1, s);
    chk("no_eop_err", drop_err, 1);
    drain();
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    chk("clr2_err", drop_err, 0);

    // T5: saturation at 3
    for (int k = 0; k < 5; k++) begin
      send(8'hA0 + 8'(k), 8'h07, 1, 1, 0, s);
      if (k == 1) chk("sat_cnt_2", drop_count, 2);
    end
    chk("sat_cnt_3", drop_count, 3);
    chk("sat_err", drop_err, 0);

    // T6: reset with two beats buffered
    out_bus.ready = 1'b0;
    send(8'hB0, 8'h00, 1, 0, 1, s);
    send(8'hB1, 8'hA5, 0, 0, 1, s);
    chk("pre_rst_valid", out_bus.valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_bus.valid, 0);
    chk("mid_rst_ready", in_bus.ready, 0);
    chk("mid_rst_count", drop_count, 0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_bus.ready = 1'b1;
    send(8'hC0, 8'hA5, 0, 0, 0, s);
    chk("post_rst_orphan", drop_err, 1);
    send(8'hC1, 8'h00, 1, 0, 1, s);
    send(8'hC2, 8'hA5, 0, 1, 1, s);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
